// File: rtl/text_buffer_ram_if.sv
// Bus bundle for the text buffer: CPU read/write port A, scan read port B,
// engine commands and engine status.
interface text_buffer_ram_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 7
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  cmd_clear;
    logic                  cmd_scroll;
    logic                  busy;
    logic                  done;
    logic                  wr_drop;

    // Requester side: drives addresses, data and commands.
    modport master (
        output we, addr_a, din_a, addr_b, cmd_clear, cmd_scroll,
        input  dout_a, dout_b, busy, done, wr_drop
    );

    // Buffer side.
    modport slave (
        input  we, addr_a, din_a, addr_b, cmd_clear, cmd_scroll,
        output dout_a, dout_b, busy, done, wr_drop
    );
endinterface

// File: rtl/text_buffer_ram.sv
// ROWS x COLS character buffer with a CPU read/write port, a read-only scan
// port, and hardware clear / scroll-up engines that take over the write port.
module text_buffer_ram #(
    parameter int unsigned           COLS       = 40,
    parameter int unsigned           ROWS       = 15,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] FILL_CHAR  = DATA_WIDTH'(7'h20),
    parameter int unsigned           RDW_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    text_buffer_ram_if.slave bus
);
    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] COPY_LAST = ADDR_WIDTH'(DEPTH - COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] FILL_BASE = ADDR_WIDTH'(DEPTH - COLS);
    localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    // Reject configurations whose storage cannot be addressed.
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_cfg
        $error("text_buffer_ram: ROWS*COLS exceeds 2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COPY  = 2'd2,
        FILL  = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic                  copy_vld;
    logic [DATA_WIDTH-1:0] copy_q;

    logic [DATA_WIDTH-1:0] dout_a_r;
    logic [DATA_WIDTH-1:0] dout_b_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  drop_r;

    logic                  a_ok_c;
    logic                  b_ok_c;
    logic                  src_ok_c;
    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;

    assign a_ok_c   = {1'b0, bus.addr_a} < DEPTH_X;
    assign b_ok_c   = {1'b0, bus.addr_b} < DEPTH_X;
    assign src_ok_c = {1'b0, src} < DEPTH_X;

    assign bus.dout_a  = dout_a_r;
    assign bus.dout_b  = dout_b_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.wr_drop = drop_r;

    // Single write port: CPU when idle, otherwise the active engine.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = bus.addr_a;
        wr_data_c = bus.din_a;
        unique case (state)
            IDLE: begin
                wr_en_c = bus.we & a_ok_c;
            end
            CLEAR, FILL: begin
                wr_en_c   = 1'b1;
                wr_addr_c = ptr;
                wr_data_c = FILL_CHAR;
            end
            COPY: begin
                wr_en_c   = copy_vld;
                wr_addr_c = dst;
                wr_data_c = copy_q;
            end
            default: begin
                wr_en_c = 1'b0;
            end
        endcase
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[IDX_W'(wr_addr_c)] <= wr_data_c;
        end
    end

    // Scan port: registered read, never stalled, sees old word on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_b_r <= '0;
        end else if (b_ok_c) begin
            dout_b_r <= mem[IDX_W'(bus.addr_b)];
        end else begin
            dout_b_r <= '0;
        end
    end

    // Engine FSM, CPU read register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            src      <= '0;
            dst      <= '0;
            copy_vld <= 1'b0;
            copy_q   <= '0;
            dout_a_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            drop_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!a_ok_c) begin
                        dout_a_r <= '0;
                    end else if ((RDW_MODE != 0) && bus.we) begin
                        dout_a_r <= bus.din_a;
                    end else begin
                        dout_a_r <= mem[IDX_W'(bus.addr_a)];
                    end
                    // Clear has priority; a simultaneous scroll is dropped.
                    if (bus.cmd_clear) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_r <= 1'b1;
                    end else if (bus.cmd_scroll) begin
                        busy_r <= 1'b1;
                        if (ROWS > 1) begin
                            state    <= COPY;
                            src      <= COLS_A;
                            dst      <= '0;
                            copy_vld <= 1'b0;
                        end else begin
                            state <= FILL;
                            ptr   <= '0;
                        end
                    end
                end
                CLEAR, FILL: begin
                    drop_r <= bus.we;
                    if (ptr == LAST) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        ptr <= ptr + ONE;
                    end
                end
                COPY: begin
                    // Read one row ahead; the write lands a row lower next cycle.
                    drop_r   <= bus.we;
                    copy_vld <= 1'b1;
                    src      <= src + ONE;
                    if (src_ok_c) begin
                        copy_q <= mem[IDX_W'(src)];
                    end
                    if (copy_vld) begin
                        dst <= dst + ONE;
                        if (dst == COPY_LAST) begin
                            state <= FILL;
                            ptr   <= FILL_BASE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_buffer_ram.sv
// Bench for text_buffer_ram: two instances (read-old and write-first) share
// stimulus; a write-list reference model feeds an expectation queue that a
// separate monitor drains every clock.
module tb_text_buffer_ram;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROWS  = 3;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 7;
    localparam logic [DW-1:0] FILL = 7'h20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_buffer_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    text_buffer_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    text_buffer_ram #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .FILL_CHAR(FILL), .RDW_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    text_buffer_ram #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .FILL_CHAR(FILL), .RDW_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign bus1.we         = bus0.we;
    assign bus1.addr_a     = bus0.addr_a;
    assign bus1.din_a      = bus0.din_a;
    assign bus1.addr_b     = bus0.addr_b;
    assign bus1.cmd_clear  = bus0.cmd_clear;
    assign bus1.cmd_scroll = bus0.cmd_scroll;

    typedef struct {
        logic [DW-1:0] da0, da1, db;
        bit            da0_k, da1_k, db_k;
        bit            busy, done, drop;
    } exp_t;

    typedef struct {
        bit            wr;
        int            addr;
        logic [DW-1:0] data;
        bit            kn;
    } op_t;

    // Reference model: array contents, which words are defined, and the list
    // of engine writes still to be performed (one per busy cycle).
    logic [DW-1:0] mem_m [DEPTH];
    bit            known [DEPTH];
    op_t           ops [$];
    exp_t          exp_q [$];
    logic [DW-1:0] m_da0 = '0, m_da1 = '0, m_db = '0;
    bit            m_da0_k = 1'b1, m_da1_k = 1'b1, m_db_k = 1'b1;
    bit            m_busy = 1'b0, m_done = 1'b0, m_drop = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Predict the outputs after the coming rising edge, queue them, advance.
    task automatic step();
        exp_t e;
        op_t  op;
        int   aa;
        int   ab;
        aa = int'(bus0.addr_a);
        ab = int'(bus0.addr_b);
        m_done = 1'b0;
        m_drop = 1'b0;
        if (!rst_n) begin
            ops.delete();
            m_da0 = '0; m_da1 = '0; m_db = '0;
            m_da0_k = 1'b1; m_da1_k = 1'b1; m_db_k = 1'b1;
        end else begin
            if (ab < DEPTH) begin
                m_db = mem_m[ab]; m_db_k = known[ab];
            end else begin
                m_db = '0; m_db_k = 1'b1;
            end
            if (ops.size() == 0) begin
                if (aa < DEPTH) begin
                    m_da0 = mem_m[aa]; m_da0_k = known[aa];
                    if (bus0.we) begin
                        m_da1 = bus0.din_a; m_da1_k = 1'b1;
                    end else begin
                        m_da1 = mem_m[aa]; m_da1_k = known[aa];
                    end
                    if (bus0.we) begin
                        mem_m[aa] = bus0.din_a; known[aa] = 1'b1;
                    end
                end else begin
                    m_da0 = '0; m_da1 = '0; m_da0_k = 1'b1; m_da1_k = 1'b1;
                end
                if (bus0.cmd_clear) begin
                    for (int i = 0; i < DEPTH; i++)
                        ops.push_back('{wr: 1'b1, addr: i, data: FILL, kn: 1'b1});
                end else if (bus0.cmd_scroll) begin
                    // Scroll = one pipeline-fill cycle, row shift, blank last row.
                    ops.push_back('{wr: 1'b0, addr: 0, data: '0, kn: 1'b0});
                    for (int d = 0; d < DEPTH - COLS; d++)
                        ops.push_back('{wr: 1'b1, addr: d, data: mem_m[d + COLS], kn: known[d + COLS]});
                    for (int d = DEPTH - COLS; d < DEPTH; d++)
                        ops.push_back('{wr: 1'b1, addr: d, data: FILL, kn: 1'b1});
                end
            end else begin
                m_drop = bus0.we;
                op = ops.pop_front();
                if (op.wr) begin
                    mem_m[op.addr] = op.data; known[op.addr] = op.kn;
                end
                if (ops.size() == 0) m_done = 1'b1;
            end
        end
        m_busy = (ops.size() > 0);
        e.da0 = m_da0; e.da0_k = m_da0_k;
        e.da1 = m_da1; e.da1_k = m_da1_k;
        e.db  = m_db;  e.db_k  = m_db_k;
        e.busy = m_busy; e.done = m_done; e.drop = m_drop;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input int aa, input int din, input int ab,
                         input bit clr, input bit scr);
        bus0.we         = we;
        bus0.addr_a     = AW'(aa);
        bus0.din_a      = DW'(din);
        bus0.addr_b     = AW'(ab);
        bus0.cmd_clear  = clr;
        bus0.cmd_scroll = scr;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ops.size() > 0 && n < 100) begin
            drive(1'b0, 0, 0, n % DEPTH, 1'b0, 1'b0);
            step();
            n++;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, i, 0, DEPTH - 1 - i, 1'b0, 1'b0);
            step();
        end
    endtask

    // Monitor: compare both instances against the oldest expectation.
    exp_t me;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("busy0", 32'(bus0.busy), 32'(me.busy));
                chk("busy1", 32'(bus1.busy), 32'(me.busy));
                chk("done0", 32'(bus0.done), 32'(me.done));
                chk("done1", 32'(bus1.done), 32'(me.done));
                chk("wr_drop0", 32'(bus0.wr_drop), 32'(me.drop));
                chk("wr_drop1", 32'(bus1.wr_drop), 32'(me.drop));
                if (me.da0_k) chk("dout_a_old", 32'(bus0.dout_a), 32'(me.da0));
                if (me.da1_k) chk("dout_a_wfirst", 32'(bus1.dout_a), 32'(me.da1));
                if (me.db_k) begin
                    chk("dout_b0", 32'(bus0.dout_b), 32'(me.db));
                    chk("dout_b1", 32'(bus1.dout_b), 32'(me.db));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b0;
        end
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic write then read on both ports, and scan read during a write.
        drive(1'b1, 5, 7'h41, 0, 1'b0, 1'b0); step();
        drive(1'b0, 5, 0, 5, 1'b0, 1'b0);     step();
        drive(1'b1, 5, 7'h42, 5, 1'b0, 1'b0); step();
        drive(1'b0, 5, 0, 5, 1'b0, 1'b0);     step();

        // Clear.
        drive(1'b0, 0, 0, 0, 1'b1, 1'b0); step();
        wait_idle();
        read_all();

        // Load 1..12 then scroll up one row.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, i, i + 1, 0, 1'b0, 1'b0); step();
        end
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1); step();
        wait_idle();
        read_all();

        // Writes and commands while busy are dropped; clear beats scroll.
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1); step();
        drive(1'b1, 2, 7'h7f, 9, 1'b0, 1'b0); step();
        drive(1'b0, 0, 0, 3, 1'b1, 1'b0); step();
        drive(1'b1, 10, 7'h11, 10, 1'b0, 1'b0); step();
        wait_idle();
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, i, 7'h30 + i, 0, 1'b0, 1'b0); step();
        end
        drive(1'b0, 0, 0, 0, 1'b1, 1'b1); step();
        wait_idle();
        read_all();

        // Reset in the sixth busy cycle of a clear, then a fresh clear.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, i, 7'h50 + i, 0, 1'b0, 1'b0); step();
        end
        drive(1'b0, 0, 0, 0, 1'b1, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 0, 11, 1'b0, 1'b0); step();
        end
        rst_n = 1'b0;
        #1;
        chk("busy_async_rst", 32'(bus0.busy), 32'd0);
        chk("done_async_rst", 32'(bus0.done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        read_all();
        drive(1'b0, 0, 0, 0, 1'b1, 1'b0); step();
        wait_idle();
        read_all();

        // Write-first read-back and out-of-range access.
        drive(1'b1, 3, 7'h55, 3, 1'b0, 1'b0);  step();
        drive(1'b1, 12, 7'h66, 12, 1'b0, 1'b0); step();
        drive(1'b0, 12, 0, 12, 1'b0, 1'b0);    step();
        drive(1'b0, 3, 0, 15, 1'b0, 1'b0);     step();

        // Randomized traffic with occasional engine commands.
        for (int i = 0; i < 900; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 127)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0));
            step();
        end
        wait_idle();
        read_all();

        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        step();
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
